// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared widths, opcodes, state encodings and the ALU function
package uart_alu_pkg;

  localparam int SIZEDATA = 8;
  localparam int SIZEOP   = 6;

  localparam logic [SIZEOP-1:0] OP_ADD = 6'b100000;
  localparam logic [SIZEOP-1:0] OP_SUB = 6'b100010;
  localparam logic [SIZEOP-1:0] OP_OR  = 6'b100101;
  localparam logic [SIZEOP-1:0] OP_XOR = 6'b100110;
  localparam logic [SIZEOP-1:0] OP_AND = 6'b100100;
  localparam logic [SIZEOP-1:0] OP_NOR = 6'b100111;
  localparam logic [SIZEOP-1:0] OP_SRA = 6'b000011;
  localparam logic [SIZEOP-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {SEQ_WAIT_A, SEQ_WAIT_B, SEQ_WAIT_OP, SEQ_SEND} seq_state_e;

  // Shifts use the whole of b, so b >= 8 empties the byte (or fills with the sign)
  function automatic logic [SIZEDATA-1:0] alu_f(input logic [SIZEDATA-1:0] a,
                                                input logic [SIZEDATA-1:0] b,
                                                input logic [SIZEOP-1:0]   op);
    logic [SIZEDATA-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_NOR:  r = ~(a | b);
      OP_SRA:  r = SIZEDATA'($signed(a) >>> b);
      OP_SRL:  r = a >> b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_alu_uart.sv
// rtl/uart_alu_uart.sv - baud tick generator, 8N1 receiver and 8N1 transmitter
module uart
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic                tx,
  input  logic                tx_start,
  input  logic [SIZEDATA-1:0] tx_byte,
  output logic                rx_done,
  output logic [SIZEDATA-1:0] rx_byte,
  output logic                tx_done
);

  localparam int DIV   = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             tick;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [OS_W-1:0]  rx_os_q, rx_os_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done_q, rx_done_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [OS_W-1:0]  tx_os_q, tx_os_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_pend_q, tx_pend_d;
  logic             tx_done_q, tx_done_d;

  assign tick = (baud_cnt_q == DIV_LAST);

  always_comb begin
    baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);
  end

  // Start is armed by a falling edge, so a low stop bit cannot re-trigger a frame
  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_os_q == OS_MID) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_os_d = rx_os_q + OS_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_os_d    = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end else begin
            rx_os_d = rx_os_q + OS_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_os_q == OS_LAST) begin
            rx_done_d  = rx_sync_q;
            rx_state_d = RX_IDLE;
          end else begin
            rx_os_d = rx_os_q + OS_W'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A request waits for the next tick so the start bit is a full 16 ticks long
  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pend_d  = tx_pend_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) tx_shift_d = tx_byte;
        if ((tx_start || tx_pend_q) && tick) begin
          tx_state_d = TX_START;
          tx_os_d    = '0;
          tx_pend_d  = 1'b0;
        end else if (tx_start) begin
          tx_pend_d = 1'b1;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_os_q == OS_LAST) begin
            tx_os_d    = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_os_d = tx_os_q + OS_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_os_q == OS_LAST) begin
            tx_os_d    = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          end else begin
            tx_os_d = tx_os_q + OS_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_os_q == OS_LAST) begin
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_os_d = tx_os_q + OS_W'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pend_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      tx_state_q <= tx_state_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pend_q  <= tx_pend_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign rx_done = rx_done_q;
  assign rx_byte = rx_shift_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_alu_top.sv
// rtl/uart_alu_top.sv - serial ALU: collects A, B, opcode over UART and sends back the result
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tx,
  output logic o_rx,
  output logic o_tx_done
);

  seq_state_e          state_q, state_d;
  logic [SIZEDATA-1:0] a_q, a_d;
  logic [SIZEDATA-1:0] b_q, b_d;
  logic [SIZEOP-1:0]   op_q, op_d;
  logic [SIZEDATA-1:0] result_q, result_d;
  logic                tx_start_q, tx_start_d;
  logic                rx_done;
  logic [SIZEDATA-1:0] rx_byte;
  logic                tx_done;

  uart #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_uart (
    .clk      (i_clock),
    .rst_n    (i_reset),
    .rx       (i_tx),
    .tx       (o_rx),
    .tx_start (tx_start_q),
    .tx_byte  (result_q),
    .rx_done  (rx_done),
    .rx_byte  (rx_byte),
    .tx_done  (tx_done)
  );

  // The result is computed straight from the arriving opcode byte; SEND drops any input
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    tx_start_d = 1'b0;
    case (state_q)
      SEQ_WAIT_A: begin
        if (rx_done) begin
          a_d     = rx_byte;
          state_d = SEQ_WAIT_B;
        end
      end
      SEQ_WAIT_B: begin
        if (rx_done) begin
          b_d     = rx_byte;
          state_d = SEQ_WAIT_OP;
        end
      end
      SEQ_WAIT_OP: begin
        if (rx_done) begin
          op_d       = rx_byte[SIZEOP-1:0];
          result_d   = alu_f(a_q, b_q, rx_byte[SIZEOP-1:0]);
          tx_start_d = 1'b1;
          state_d    = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        if (tx_done) state_d = SEQ_WAIT_A;
      end
      default: state_d = SEQ_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= SEQ_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_tx_done = tx_done;

endmodule

// File: tb/tb_uart_alu_top.sv
// tb/tb_uart_alu_top.sv - table-driven bench with a serial host model and result scoreboard
module tb_uart_alu_top;

  localparam int CLK_FREQ   = 5_000_000;
  localparam int BAUD_RATE  = 78125;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 4 * OVERSAMPLE;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_tx    = 1'b1;
  logic o_rx;
  logic o_tx_done;

  int n_vec = 0;
  int n_bad = 0;
  int frames = 0;
  int exp_frames = 0;
  int txd_cnt = 0;
  logic abort_frame = 1'b0;
  logic [7:0] exp_q[$];
  vec_t vecs[16];

  uart_alu_top #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_tx      (i_tx),
    .o_rx      (o_rx),
    .o_tx_done (o_tx_done)
  );

  always #100 i_clock = ~i_clock;

  always @(negedge i_clock) if (o_tx_done === 1'b1) txd_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host receiver: samples each bit of the result frame at its midpoint
  initial begin
    logic [7:0] d;
    logic       st, sp;
    forever begin
      @(negedge o_rx);
      if (i_reset === 1'b1) begin
        repeat (BIT_CLKS / 2) @(negedge i_clock);
        st = o_rx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge i_clock);
          d[i] = o_rx;
        end
        repeat (BIT_CLKS) @(negedge i_clock);
        sp = o_rx;
        if (!abort_frame) begin
          check($sformatf("frame_shape_%0d", frames), {30'd0, st, sp}, 32'd1);
          if (exp_q.size() == 0) check("unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
          else check($sformatf("result_%0d", frames), {24'd0, d}, {24'd0, exp_q.pop_front()});
          frames++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    i_tx = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clock);
    for (int i = 0; i < 8; i++) begin
      i_tx = d[i];
      repeat (BIT_CLKS) @(negedge i_clock);
    end
    i_tx = stop;
    repeat (BIT_CLKS) @(negedge i_clock);
    i_tx = 1'b1;
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 3000 && frames < exp_frames; i++) @(negedge i_clock);
    check({name, "_frames"}, frames, exp_frames);
    repeat (BIT_CLKS) @(negedge i_clock);
    check({name, "_tx_done"}, txd_cnt, exp_frames);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] res, input string name);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    exp_q.push_back(res);
    exp_frames++;
    send_byte(op, 1'b1);
    wait_result(name);
  endtask

  initial begin
    vecs[0]  = '{8'h04, 8'h08, 8'h20, 8'h0C};
    vecs[1]  = '{8'h04, 8'h08, 8'h22, 8'hFC};
    vecs[2]  = '{8'h04, 8'h08, 8'h25, 8'h0C};
    vecs[3]  = '{8'h04, 8'h08, 8'h26, 8'h0C};
    vecs[4]  = '{8'h04, 8'h08, 8'h24, 8'h00};
    vecs[5]  = '{8'h04, 8'h08, 8'h27, 8'hF3};
    vecs[6]  = '{8'h80, 8'h02, 8'h03, 8'hE0};
    vecs[7]  = '{8'h80, 8'h02, 8'h02, 8'h20};
    vecs[8]  = '{8'h04, 8'h08, 8'h03, 8'h00};
    vecs[9]  = '{8'h04, 8'h08, 8'h02, 8'h00};
    vecs[10] = '{8'h04, 8'h08, 8'h3F, 8'h00};
    vecs[11] = '{8'hA3, 8'h5C, 8'h20, 8'hFF};
    vecs[12] = '{8'h10, 8'h20, 8'hE0, 8'h30};
    vecs[13] = '{8'h80, 8'h09, 8'h03, 8'hFF};
    vecs[14] = '{8'h7F, 8'h01, 8'h22, 8'h7E};
    vecs[15] = '{8'hF0, 8'h33, 8'h26, 8'hC3};

    #10 i_reset = 1'b0;
    #1;
    check("reset_o_rx", {31'd0, o_rx}, 32'd1);
    check("reset_o_tx_done", {31'd0, o_tx_done}, 32'd0);
    repeat (5) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (BIT_CLKS) @(negedge i_clock);
    check("idle_o_rx", {31'd0, o_rx}, 32'd1);

    for (int v = 0; v < 16; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].res, $sformatf("vec%0d", v));

    // Framing errors before A and between A and B must leave the sequence intact
    send_byte(8'h55, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge i_clock);
    send_byte(8'h04, 1'b1);
    send_byte(8'hAA, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge i_clock);
    send_byte(8'h08, 1'b1);
    exp_q.push_back(8'h0C);
    exp_frames++;
    send_byte(8'h20, 1'b1);
    wait_result("framing");

    // Reset in the middle of operand B
    send_byte(8'h04, 1'b1);
    i_tx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("rst_b_o_rx", {31'd0, o_rx}, 32'd1);
    check("rst_b_o_tx_done", {31'd0, o_tx_done}, 32'd0);
    i_tx = 1'b1;
    repeat (5) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge i_clock);
    run_op(8'h04, 8'h08, 8'h20, 8'h0C, "after_rst_b");

    // Reset while the result frame is on the line
    send_byte(8'h04, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h20, 1'b1);
    for (int i = 0; i < 2000 && o_rx !== 1'b0; i++) @(negedge i_clock);
    check("rst_tx_started", {31'd0, o_rx}, 32'd0);
    abort_frame = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("rst_tx_o_rx", {31'd0, o_rx}, 32'd1);
    check("rst_tx_o_tx_done", {31'd0, o_tx_done}, 32'd0);
    repeat (5) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge i_clock);
    abort_frame = 1'b0;
    check("rst_tx_no_done", txd_cnt, exp_frames);
    check("rst_tx_line_idle", {31'd0, o_rx}, 32'd1);
    run_op(8'h80, 8'h02, 8'h03, 8'hE0, "after_rst_tx");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
